// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle MIPS-style datapath with a handshaked memory bus
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  state_t st;
  logic op_lw, op_sw, op_r, op_beq, op_addi, op_j;
  assign op_lw   = OPcode == 6'b100011;
  assign op_sw   = OPcode == 6'b101011;
  assign op_r    = OPcode == 6'b000000;
  assign op_beq  = OPcode == 6'b000100;
  assign op_addi = OPcode == 6'b001000;
  assign op_j    = OPcode == 6'b000010;
  assign state   = st;
  // State register; OPcode only steers transitions out of DECODE and MEMADR
  always_ff @(posedge clk) begin
    if (rst) st <= FETCH;
    else
      case (st)
        FETCH:   st <= mem_ready ? DECODE : FETCH;
        DECODE:  st <= (op_lw || op_sw) ? MEMADR :
                       op_r    ? EXEC   :
                       op_beq  ? BRANCH :
                       op_addi ? ADDIEX :
                       op_j    ? JUMP   : FETCH;
        MEMADR:  st <= op_lw ? MEMRD : MEMWR;
        MEMRD:   st <= mem_ready ? MEMWB : MEMRD;
        MEMWR:   st <= mem_ready ? FETCH : MEMWR;
        EXEC:    st <= ALUWB;
        ADDIEX:  st <= ADDIWB;
        default: st <= FETCH;
      endcase
  end
  // Per-state control decode; write/request strobes are forced low during reset
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCEn       = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !(op_lw || op_sw || op_r || op_beq || op_addi || op_j);
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCEn    = Zero;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req    = 1'b0;
      IRWrite    = 1'b0;
      PCEn       = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 OPcode  input  6  instruction[31:26], sampled from the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completion for the current access.
REQ-007 mem_req  output  1  memory access request; held until mem_ready.
REQ-008 IorD  output  1  address select: 0 = PC, 1 = ALUOut.
REQ-009 MemWrite  output  1  memory write strobe.
REQ-010 IRWrite  output  1  instruction register load.
REQ-011 PCEn  output  1  PC register enable.
REQ-012 PCSrc  output  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-014 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
REQ-015 ALUOp  output  2  00 add, 01 sub, 10 decode Funct, feeds the existing ALU decoder.
REQ-016 RegDst  output  1  0 = rt, 1 = rd.
REQ-017 MemtoReg  output  1  0 = ALUOut, 1 = memory data.
REQ-018 RegWrite  output  1  register file write enable.
REQ-019 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-020 state  output  4  current state encoding, for debug.

Function
REQ-021 The states and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 SHALL go to FETCH on the next cycle.
REQ-022 All outputs except PCEn, IRWrite and illegal_op SHALL be pure functions of the state (Moore); every output not listed for a state SHALL be 0.
REQ-023 FETCH SHALL assert mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite and PCEn SHALL be 1 only in the cycle where mem_ready=1.
REQ-024 FETCH SHALL hold while mem_ready=0, and SHALL move to DECODE on mem_ready=1.
REQ-025 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, then branch on OPcode: 100011/101011 to MEMADR; 000000 to EXEC; 000100 to BRANCH; 001000 to ADDIEX; 000010 to JUMP.
REQ-026 In DECODE, any other opcode SHALL pulse illegal_op for 1 cycle and go to FETCH.
REQ-027 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-028 MEMRD SHALL drive mem_req=1, IorD=1, hold until mem_ready, then go to MEMWB.
REQ-029 MEMWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=1, then go to FETCH.
REQ-030 MEMWR SHALL drive mem_req=1, IorD=1 and MemWrite=1 while waiting; on mem_ready it SHALL go to FETCH.
REQ-031 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-032 ALUWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-033 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, with PCEn=Zero, then go to FETCH.
REQ-034 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
REQ-035 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-036 JUMP SHALL drive PCSrc=10, PCEn=1, then go to FETCH.
REQ-037 OPcode SHALL be sampled only in DECODE and MEMADR; changes in any other state SHALL have no effect.
REQ-038 The bus is zero-wait when mem_ready is held at 1; with that, cycles per instruction SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-039 With rst=1 at a rising edge, state SHALL become FETCH, overriding any transition including a pending mem_ready.
REQ-040 While rst=1, mem_req, IRWrite, PCEn, MemWrite, RegWrite and illegal_op SHALL be 0.
REQ-041 After reset releases, the first fetch SHALL begin on the following cycle.

Verification
REQ-042 Bench SHALL run lw (100011) with mem_ready held at 1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4, with MemtoReg=1.
REQ-043 Bench SHALL run sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, RegWrite never 1, return to FETCH.
REQ-044 Bench SHALL run beq twice, with Zero=1 then Zero=0 in BRANCH -> PCEn=1 with PCSrc=01 in the first case; PCEn=0 in the second.
REQ-045 Bench SHALL present OPcode=111111 in DECODE -> illegal_op=1 for exactly one cycle, next state FETCH, no RegWrite or MemWrite.
REQ-046 Bench SHALL assert rst in MEMRD while mem_ready=1 -> state 0 next cycle, no MEMWB, RegWrite stays 0.
REQ-047 Bench SHALL hold mem_ready=0 for 5 cycles in FETCH -> IRWrite=0 and PCEn=0 throughout, then both 1 for exactly one cycle.
